fc_weight_loader: RTL and testbench
===================================

FC_WEIGHT_LOADER -- requirements
Module: fc_weight_loader

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of one weight/bias word.
REQ-002 Parameter LAYER_HEIGHT, default 2: neurons in target layer; words per memory row.
REQ-003 Parameter PREVIOUS_LAYER_HEIGHT, default 4: weight rows; total rows = PREVIOUS_LAYER_HEIGHT+1, last row is bias.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  clock; all state changes on rising edge.
REQ-006 reset_i  input  1  asynchronous active-high reset.
REQ-007 start_i  input  1  request a full reload; sampled only in IDLE.
REQ-008 abort_i  input  1  cancel an in-progress load.
REQ-009 data_i  input  WORD_SIZE  incoming weight/bias word.
REQ-010 valid_i  input  1  data_i valid.
REQ-011 ready_o  output  1  loader accepts data_i; transfer when valid_i && ready_o.
REQ-012 weight_o  output  [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]  assembled row to layer weight port.
REQ-013 waddr_o  output  $clog2(PREVIOUS_LAYER_HEIGHT+1)  row address, 0..PREVIOUS_LAYER_HEIGHT.
REQ-014 mem_wen_o  output  1  one-cycle row write strobe.
REQ-015 infer_en_o  output  1  high only in IDLE; gates layer inference during load.
REQ-016 busy_o  output  1  high in FILL or WRITE.
REQ-017 done_o  output  1  one-cycle pulse on successful completion.

Function
REQ-018 FSM states SHALL be IDLE, FILL, WRITE, DONE.
REQ-019 IDLE: ready_o=0; start_i=1 -> FILL, clearing word counter (col) and row counter (row) to 0.
REQ-020 FILL: ready_o=1; each transfer stores data_i into lane col of row buffer (first word -> lane 0), col increments.
REQ-021 FILL: transfer with col==LAYER_HEIGHT-1 -> WRITE, col cleared; valid_i low holds state and counters.
REQ-022 WRITE: exactly one cycle; ready_o=0, mem_wen_o=1, waddr_o=row, weight_o=complete row buffer.
REQ-023 WRITE: row==PREVIOUS_LAYER_HEIGHT -> DONE; else row increments -> FILL.
REQ-024 DONE: exactly one cycle; done_o=1 -> IDLE.
REQ-025 Latency: last word of a row accepted at edge t -> mem_wen_o high in cycle t+1.
REQ-026 Minimum load duration with valid_i held high: (PREVIOUS_LAYER_HEIGHT+1)*(LAYER_HEIGHT+1)+1 cycles from FILL entry to DONE exit.
REQ-027 start_i outside IDLE SHALL be ignored; start_i in DONE does not retrigger.
REQ-028 abort_i in FILL or WRITE -> IDLE next cycle, no mem_wen_o in that cycle, no done_o; abort_i has priority over transfer and over WRITE; ignored in IDLE/DONE.
REQ-029 weight_o and waddr_o SHALL hold last written values outside WRITE; mem_wen_o low outside WRITE.
REQ-030 Words SHALL be stored without arithmetic modification (bit-exact, signed two's complement).
REQ-031 Counters SHALL never exceed LAYER_HEIGHT-1 (col) and PREVIOUS_LAYER_HEIGHT (row); no wrap within a load.

Reset
REQ-032 reset_i asserted, at any time including mid-load, SHALL immediately force IDLE, col=row=0, row buffer=0, weight_o=0, waddr_o=0, mem_wen_o=0, ready_o=0, busy_o=0, done_o=0, infer_en_o=1.
REQ-033 After reset deassertion no write occurs until a new start_i.

Verification
REQ-034 Defaults, start_i then words 1..10 with valid_i constant -> writes addr0={1,2}, 1={3,4}, 2={5,6}, 3={7,8}, 4={9,10} (lane0 first), done_o one pulse, 16 cycles FILL entry to DONE exit.
REQ-035 Same load with valid_i toggling 1/0 each cycle -> identical write contents/addresses, no extra strobes, ready_o low during every WRITE.
REQ-036 abort_i at WRITE of row 2 -> only rows 0,1 written, no done_o, infer_en_o=1 next cycle; new start_i then reloads from row 0.
REQ-037 reset_i asserted after 5 words accepted -> all outputs at reset values same cycle asynchronously; 3 writes never appear.
REQ-038 start_i pulsed during FILL and in DONE -> no restart, counters unaffected, exactly 5 strobes per load.
REQ-039 Data 0x8000 and 0x7FFF as row 0 -> weight_o lanes bit-exact 0x8000, 0x7FFF at addr 0.

Source files
------------

// File: rtl/fc_weight_loader.sv
// Streams weight/bias words into a row buffer and writes one assembled row per
// memory address, then pulses done_o. Layer inference is only enabled while idle.
module fc_weight_loader #(
    parameter int WORD_SIZE             = 16,
    parameter int LAYER_HEIGHT          = 2,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    localparam int ADDR_W               = $clog2(PREVIOUS_LAYER_HEIGHT + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   start_i,
    input  logic                                   abort_i,
    input  logic [WORD_SIZE-1:0]                   data_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    output logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] weight_o,
    output logic [ADDR_W-1:0]                      waddr_o,
    output logic                                   mem_wen_o,
    output logic                                   infer_en_o,
    output logic                                   busy_o,
    output logic                                   done_o
);

    localparam int COL_W = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(LAYER_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(PREVIOUS_LAYER_HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } state_t;

    state_t                                 state_q, state_d;
    logic [COL_W-1:0]                       col_q, col_d;
    logic [ADDR_W-1:0]                      row_q, row_d;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] buf_q, buf_d;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] weight_q, weight_d;
    logic [ADDR_W-1:0]                      waddr_q, waddr_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            buf_q    <= '0;
            weight_q <= '0;
            waddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            buf_q    <= buf_d;
            weight_q <= weight_d;
            waddr_q  <= waddr_d;
        end
    end

    // Abort wins over both a word transfer and the row write.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        buf_d    = buf_q;
        weight_d = weight_q;
        waddr_d  = waddr_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FILL;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            FILL: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (valid_i) begin
                    buf_d[col_q] = data_i;
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = WRITE;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            WRITE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    weight_d = buf_q;
                    waddr_d  = row_q;
                    if (row_q == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + ADDR_W'(1);
                        state_d = FILL;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The live row is presented during WRITE; the last committed row is held otherwise.
    always_comb begin
        ready_o    = (state_q == FILL);
        mem_wen_o  = (state_q == WRITE) && !abort_i;
        weight_o   = (state_q == WRITE) ? buf_q : weight_q;
        waddr_o    = (state_q == WRITE) ? row_q : waddr_q;
        infer_en_o = (state_q == IDLE);
        busy_o     = (state_q == FILL) || (state_q == WRITE);
        done_o     = (state_q == DONE);
    end

endmodule

// File: tb/tb_fc_weight_loader.sv
// Scoreboard bench for fc_weight_loader: directed loads push expected rows into a
// queue that a negedge monitor drains on every write strobe.
module tb_fc_weight_loader;

    localparam int W    = 16;
    localparam int LH   = 2;
    localparam int PLH  = 4;
    localparam int ROWS = PLH + 1;
    localparam int AW   = $clog2(PLH + 1);

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic                  start_i;
    logic                  abort_i;
    logic [W-1:0]          data_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [LH-1:0][W-1:0]  weight_o;
    logic [AW-1:0]         waddr_o;
    logic                  mem_wen_o;
    logic                  infer_en_o;
    logic                  busy_o;
    logic                  done_o;

    typedef struct {
        int                   addr;
        logic [LH-1:0][W-1:0] row;
    } exp_t;

    exp_t         expQ[$];
    exp_t         monExp;
    int           checks       = 0;
    int           failures     = 0;
    int           strobeCount  = 0;
    int           doneCount    = 0;
    int           activeCycles = 0;
    logic [W-1:0] words[ROWS*LH];

    fc_weight_loader #(
        .WORD_SIZE(W),
        .LAYER_HEIGHT(LH),
        .PREVIOUS_LAYER_HEIGHT(PLH)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .start_i(start_i),
        .abort_i(abort_i),
        .data_i(data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .weight_o(weight_o),
        .waddr_o(waddr_o),
        .mem_wen_o(mem_wen_o),
        .infer_en_o(infer_en_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [63:0] actual,
                                        input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endfunction

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (busy_o || done_o) activeCycles++;
            if (done_o) doneCount++;
            if (mem_wen_o) begin
                strobeCount++;
                checkOutput("ready_in_write", 64'(ready_o), 64'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_strobe actual=addr%0d required=none", waddr_o);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("waddr", 64'(waddr_o), 64'(monExp.addr));
                    checkOutput("weight", 64'(weight_o), 64'(monExp.row));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] w, input bit toggle);
        int t = 0;
        bit acc = 1'b0;
        data_i  = w;
        valid_i = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 20) begin
                checks++;
                failures++;
                $display("[TB] FAIL accept_timeout actual=not_ready required=ready");
                break;
            end
        end
        if (toggle) begin
            valid_i = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runLoad(input bit toggle, input bit startMid, input int nWords,
                           input int nRowsExp);
        exp_t e;
        for (int r = 0; r < nRowsExp; r++) begin
            e.addr = r;
            for (int l = 0; l < LH; l++) e.row[l] = words[r*LH+l];
            expQ.push_back(e);
        end
        activeCycles = 0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < nWords; i++) begin
            if (startMid && i == 3) start_i = 1'b1;
            applyStimulus(words[i], toggle);
        end
        valid_i = 1'b0;
    endtask

    task automatic waitDone();
        int t = 0;
        while (1) begin
            @(negedge clk);
            if (done_o) break;
            t++;
            if (t > 40) begin
                checks++;
                failures++;
                $display("[TB] FAIL done_timeout actual=no_done required=done");
                break;
            end
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic setCountingWords();
        for (int i = 0; i < ROWS*LH; i++) words[i] = W'(i + 1);
    endtask

    initial begin
        int doneBefore;
        int strobeBefore;
        reset_i = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        setCountingWords();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 64'(ready_o), 64'd0);
        checkOutput("rst_infer", 64'(infer_en_o), 64'd1);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_weight", 64'(weight_o), 64'd0);
        checkOutput("rst_waddr", 64'(waddr_o), 64'd0);
        #1 reset_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_no_start_busy", 64'(busy_o), 64'd0);

        // Constant-valid load with latency measurement
        doneBefore = doneCount;
        strobeBefore = strobeCount;
        runLoad(1'b0, 1'b0, ROWS*LH, ROWS);
        waitDone();
        checkOutput("const_latency", 64'(activeCycles), 64'd16);
        checkOutput("const_done_pulses", 64'(doneCount - doneBefore), 64'd1);
        checkOutput("const_strobes", 64'(strobeCount - strobeBefore), 64'd5);
        checkOutput("const_infer_after", 64'(infer_en_o), 64'd1);

        // Toggling valid
        strobeBefore = strobeCount;
        runLoad(1'b1, 1'b0, ROWS*LH, ROWS);
        waitDone();
        checkOutput("toggle_strobes", 64'(strobeCount - strobeBefore), 64'd5);

        // Abort at WRITE of row 2
        doneBefore = doneCount;
        runLoad(1'b0, 1'b0, 6, 2);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        checkOutput("abort_infer", 64'(infer_en_o), 64'd1);
        checkOutput("abort_busy", 64'(busy_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 64'(doneCount - doneBefore), 64'd0);
        checkOutput("abort_queue_empty", 64'(expQ.size()), 64'd0);
        strobeBefore = strobeCount;
        runLoad(1'b0, 1'b0, ROWS*LH, ROWS);
        waitDone();
        checkOutput("reload_strobes", 64'(strobeCount - strobeBefore), 64'd5);

        // Asynchronous reset mid-load after five words
        runLoad(1'b0, 1'b0, 5, 2);
        #2 reset_i = 1'b1;
        #1;
        checkOutput("midrst_ready", 64'(ready_o), 64'd0);
        checkOutput("midrst_busy", 64'(busy_o), 64'd0);
        checkOutput("midrst_infer", 64'(infer_en_o), 64'd1);
        checkOutput("midrst_wen", 64'(mem_wen_o), 64'd0);
        checkOutput("midrst_done", 64'(done_o), 64'd0);
        checkOutput("midrst_weight", 64'(weight_o), 64'd0);
        checkOutput("midrst_waddr", 64'(waddr_o), 64'd0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        strobeBefore = strobeCount;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("postrst_no_write", 64'(strobeCount - strobeBefore), 64'd0);
        checkOutput("postrst_queue_empty", 64'(expQ.size()), 64'd0);

        // start_i held from mid-FILL through DONE
        doneBefore = doneCount;
        strobeBefore = strobeCount;
        runLoad(1'b0, 1'b1, ROWS*LH, ROWS);
        waitDone();
        checkOutput("startmid_latency", 64'(activeCycles), 64'd16);
        checkOutput("startmid_strobes", 64'(strobeCount - strobeBefore), 64'd5);
        checkOutput("startmid_done", 64'(doneCount - doneBefore), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("startmid_no_retrigger", 64'(busy_o), 64'd0);

        // Signed extremes in row 0, then hold of last written row
        words[0] = 16'h8000;
        words[1] = 16'h7FFF;
        runLoad(1'b0, 1'b0, ROWS*LH, ROWS);
        waitDone();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("hold_weight", 64'(weight_o), {32'd0, 16'd10, 16'd9});
        checkOutput("hold_waddr", 64'(waddr_o), 64'd4);
        checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
